// File: rtl/fu_matrix_ls_engine_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fu_matrix_ls_engine_pkg                                                |
// | Shared types for the matrix load/store engine: FSM states, op codes,   |
// | request/done bundles.                                                  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package fu_matrix_ls_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } matls_state_t;

  typedef logic [1:0] matls_op_t;

  localparam matls_op_t MATLS_NONE  = 2'b00;
  localparam matls_op_t MATLS_LOAD  = 2'b01;
  localparam matls_op_t MATLS_STORE = 2'b10;

  // Widths of the default configuration, used by the bundle types below.
  localparam int C_ADDR_W    = 32;
  localparam int C_MREG_W    = 4;
  localparam int C_ROW_IDX_W = 2;

  typedef struct packed {
    logic                   req;
    logic                   ren;
    logic                   wen;
    logic [C_ADDR_W-1:0]    addr;
    logic [C_ROW_IDX_W-1:0] row;
    logic [C_MREG_W-1:0]    mreg;
  } fu_matls_req_t;

  typedef struct packed {
    logic                done;
    logic [C_MREG_W-1:0] rd;
    matls_op_t           ls;
  } fu_matls_done_t;

  // Both bits set resolves to a load.
  function automatic matls_op_t matls_decode(input logic [1:0] ls);
    matls_op_t op;
    op = MATLS_NONE;
    if (ls[0]) begin
      op = MATLS_LOAD;
    end else if (ls[1]) begin
      op = MATLS_STORE;
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fu_matrix_ls_engine_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fu_matrix_ls_engine_if                                                 |
// | Issue, memory and done sides of the matrix load/store engine.          |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface fu_matrix_ls_engine_if #(
  parameter int ADDR_W    = 32,
  parameter int IMM_W     = 11,
  parameter int STRIDE_W  = 32,
  parameter int MREG_W    = 4,
  parameter int ROWS      = 4,
  parameter int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) ();

  logic                 CLK;
  logic                 nRST;
  logic                 enable;
  logic [1:0]           ls_in;
  logic [MREG_W-1:0]    rd_in;
  logic [ADDR_W-1:0]    base_in;
  logic [IMM_W-1:0]     imm_in;
  logic [STRIDE_W-1:0]  stride_in;
  logic                 flush;
  logic                 ready_out;
  logic                 busy;
  logic                 mem_req;
  logic                 mem_ren;
  logic                 mem_wen;
  logic [ADDR_W-1:0]    mem_addr;
  logic [ROW_IDX_W-1:0] mem_row;
  logic [MREG_W-1:0]    mem_reg;
  logic                 mem_hit;
  logic                 done;
  logic [MREG_W-1:0]    done_rd;
  logic [1:0]           done_ls;

  modport engine (
    input  CLK, nRST, enable, ls_in, rd_in, base_in, imm_in, stride_in, flush, mem_hit,
    output ready_out, busy, mem_req, mem_ren, mem_wen, mem_addr, mem_row, mem_reg,
           done, done_rd, done_ls
  );

  modport tb (
    output CLK, nRST, enable, ls_in, rd_in, base_in, imm_in, stride_in, flush, mem_hit,
    input  ready_out, busy, mem_req, mem_ren, mem_wen, mem_addr, mem_row, mem_reg,
           done, done_rd, done_ls
  );

endinterface
`default_nettype wire

// File: rtl/fu_matrix_ls_engine_agen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fu_matrix_ls_agen                                                      |
// | Registered row address generator: base+imm on load, +stride per step.  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module fu_matrix_ls_agen #(
  parameter int ADDR_W    = 32,
  parameter int IMM_W     = 11,
  parameter int STRIDE_W  = 32,
  parameter int ROWS      = 4,
  parameter int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 step,
  input  logic [ADDR_W-1:0]    base,
  input  logic [IMM_W-1:0]     imm,
  input  logic [STRIDE_W-1:0]  stride,
  output logic [ADDR_W-1:0]    addr,
  output logic [ROW_IDX_W-1:0] row,
  output logic                 last
);

  localparam logic [ROW_IDX_W-1:0] c_last_row = ROW_IDX_W'(ROWS - 1);

  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    r_stride;
  logic [ROW_IDX_W-1:0] r_row;

  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_row    <= '0;
    end else if (clear) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_row    <= '0;
    end else if (load) begin
      r_addr   <= base + ADDR_W'(imm);
      r_stride <= ADDR_W'(stride);
      r_row    <= '0;
    end else if (step && (r_row != c_last_row)) begin
      r_addr   <= r_addr + r_stride;
      r_row    <= r_row + ROW_IDX_W'(1);
    end
  end

  assign addr = r_addr;
  assign row  = r_row;
  assign last = (r_row == c_last_row);

endmodule
`default_nettype wire

// File: rtl/fu_matrix_ls_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fu_matrix_ls_engine                                                    |
// | Sequential matrix load/store unit: one op expands into ROWS row        |
// | requests, each held until mem_hit, followed by a one-cycle done pulse. |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module fu_matrix_ls_engine
  import fu_matrix_ls_engine_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int IMM_W     = 11,
  parameter int STRIDE_W  = 32,
  parameter int MREG_W    = 4,
  parameter int ROWS      = 4,
  parameter int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 enable,
  input  logic [1:0]           ls_in,
  input  logic [MREG_W-1:0]    rd_in,
  input  logic [ADDR_W-1:0]    base_in,
  input  logic [IMM_W-1:0]     imm_in,
  input  logic [STRIDE_W-1:0]  stride_in,
  input  logic                 flush,
  output logic                 ready_out,
  output logic                 busy,
  output logic                 mem_req,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [ROW_IDX_W-1:0] mem_row,
  output logic [MREG_W-1:0]    mem_reg,
  input  logic                 mem_hit,
  output logic                 done,
  output logic [MREG_W-1:0]    done_rd,
  output logic [1:0]           done_ls
);

  matls_state_t         r_state;
  matls_state_t         w_next_state;
  logic [MREG_W-1:0]    r_rd;
  matls_op_t            r_op;
  logic                 w_accept;
  logic                 w_step;
  logic                 w_last;
  logic [ADDR_W-1:0]    w_addr;
  logic [ROW_IDX_W-1:0] w_row;

  // Flush in IDLE wins over a coincident enable.
  assign w_accept = (r_state == IDLE) && enable && (ls_in != 2'b00) && !flush;

  fu_matrix_ls_agen #(
    .ADDR_W    (ADDR_W),
    .IMM_W     (IMM_W),
    .STRIDE_W  (STRIDE_W),
    .ROWS      (ROWS),
    .ROW_IDX_W (ROW_IDX_W)
  ) u_agen (
    .clk    (CLK),
    .rst_n  (nRST),
    .clear  (flush),
    .load   (w_accept),
    .step   (w_step),
    .base   (base_in),
    .imm    (imm_in),
    .stride (stride_in),
    .addr   (w_addr),
    .row    (w_row),
    .last   (w_last)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_rd    <= '0;
      r_op    <= MATLS_NONE;
    end else begin
      r_state <= w_next_state;
      if (flush) begin
        r_rd <= '0;
        r_op <= MATLS_NONE;
      end else if (w_accept) begin
        r_rd <= rd_in;
        r_op <= matls_decode(ls_in);
      end
    end
  end

  // Next state plus outputs; all outputs derive from registers only.
  always_comb begin
    w_next_state = r_state;
    w_step       = 1'b0;
    ready_out    = 1'b0;
    busy         = 1'b0;
    mem_req      = 1'b0;
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    mem_addr     = '0;
    mem_row      = '0;
    mem_reg      = '0;
    done         = 1'b0;
    done_rd      = '0;
    done_ls      = 2'b00;

    case (r_state)
      IDLE: begin
        ready_out = 1'b1;
        if (w_accept) begin
          w_next_state = REQ;
        end
      end
      REQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_ren  = r_op[0];
        mem_wen  = r_op[1];
        mem_addr = w_addr;
        mem_row  = w_row;
        mem_reg  = r_rd;
        if (mem_hit && !flush) begin
          if (w_last) begin
            w_next_state = DONE;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        done_rd      = r_rd;
        done_ls      = r_op;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    if (flush) begin
      w_next_state = IDLE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fu_matrix_ls_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fu_matrix_ls_engine                                                 |
// | Scoreboard bench: expected row requests and done pulses are queued at  |
// | issue and retired as the engine produces them.                         |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_fu_matrix_ls_engine;

  localparam int ADDR_W    = 32;
  localparam int IMM_W     = 11;
  localparam int STRIDE_W  = 32;
  localparam int MREG_W    = 4;
  localparam int ROWS      = 4;
  localparam int ROW_IDX_W = 2;

  typedef struct {
    logic [ADDR_W-1:0]    addr;
    logic [ROW_IDX_W-1:0] row;
    logic [MREG_W-1:0]    mreg;
    logic                 ren;
    logic                 wen;
  } req_exp_t;

  typedef struct {
    logic [MREG_W-1:0] rd;
    logic [1:0]        ls;
  } done_exp_t;

  req_exp_t  exp_req[$];
  done_exp_t exp_done[$];
  int        checks = 0;
  int        errors = 0;

  fu_matrix_ls_engine_if #(
    .ADDR_W(ADDR_W), .IMM_W(IMM_W), .STRIDE_W(STRIDE_W),
    .MREG_W(MREG_W), .ROWS(ROWS), .ROW_IDX_W(ROW_IDX_W)
  ) bus ();

  fu_matrix_ls_engine #(
    .ADDR_W(ADDR_W), .IMM_W(IMM_W), .STRIDE_W(STRIDE_W),
    .MREG_W(MREG_W), .ROWS(ROWS), .ROW_IDX_W(ROW_IDX_W)
  ) dut (
    .CLK       (bus.CLK),
    .nRST      (bus.nRST),
    .enable    (bus.enable),
    .ls_in     (bus.ls_in),
    .rd_in     (bus.rd_in),
    .base_in   (bus.base_in),
    .imm_in    (bus.imm_in),
    .stride_in (bus.stride_in),
    .flush     (bus.flush),
    .ready_out (bus.ready_out),
    .busy      (bus.busy),
    .mem_req   (bus.mem_req),
    .mem_ren   (bus.mem_ren),
    .mem_wen   (bus.mem_wen),
    .mem_addr  (bus.mem_addr),
    .mem_row   (bus.mem_row),
    .mem_reg   (bus.mem_reg),
    .mem_hit   (bus.mem_hit),
    .done      (bus.done),
    .done_rd   (bus.done_rd),
    .done_ls   (bus.done_ls)
  );

  initial bus.CLK = 1'b0;
  always #5 bus.CLK = ~bus.CLK;

  task automatic tick();
    @(posedge bus.CLK);
    #1;
  endtask

  // Drive one op for a single cycle and queue what the engine must produce.
  task automatic issue(input logic [MREG_W-1:0] rd, input logic [1:0] ls,
                       input logic [ADDR_W-1:0] base, input logic [IMM_W-1:0] imm,
                       input logic [STRIDE_W-1:0] stride);
    req_exp_t          e;
    done_exp_t         d;
    logic [ADDR_W-1:0] a;
    logic [1:0]        op;
    op = ls[0] ? 2'b01 : 2'b10;
    a  = base + {{(ADDR_W-IMM_W){1'b0}}, imm};
    for (int r = 0; r < ROWS; r++) begin
      e.addr = a;
      e.row  = ROW_IDX_W'(r);
      e.mreg = rd;
      e.ren  = op[0];
      e.wen  = op[1];
      exp_req.push_back(e);
      a = a + stride;
    end
    d.rd = rd;
    d.ls = op;
    exp_done.push_back(d);
    checks++;
    if (bus.ready_out !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: ready_out=%b expected 1", bus.ready_out);
    end
    bus.enable    = 1'b1;
    bus.rd_in     = rd;
    bus.ls_in     = ls;
    bus.base_in   = base;
    bus.imm_in    = imm;
    bus.stride_in = stride;
    tick();
    bus.enable = 1'b0;
    bus.ls_in  = 2'b00;
  endtask

  // Answer requests (hit every hit_period-th cycle), retire scoreboard entries.
  // poke_cycle > 0 drives a competing op on that cycle.
  task automatic serve(input int hit_period, input int poke_cycle,
                       output int done_cycle, output int ndone);
    logic hit;
    bit   fin;
    done_cycle = -1;
    ndone      = 0;
    fin        = 1'b0;
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      hit         = ((cyc % hit_period) == 0);
      bus.mem_hit = hit;
      if (cyc == poke_cycle) begin
        bus.enable  = 1'b1;
        bus.rd_in   = 4'd9;
        bus.ls_in   = 2'b10;
        bus.base_in = 32'hDEAD_0000;
      end else begin
        bus.enable = 1'b0;
        bus.ls_in  = 2'b00;
      end
      if (bus.mem_req === 1'b1) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: addr=%h row=%0d", bus.mem_addr, bus.mem_row);
        end else if (bus.mem_addr !== exp_req[0].addr || bus.mem_row !== exp_req[0].row ||
                     bus.mem_reg !== exp_req[0].mreg || bus.mem_ren !== exp_req[0].ren ||
                     bus.mem_wen !== exp_req[0].wen) begin
          errors++;
          $display("FAIL req_fields: got addr=%h row=%0d reg=%0d ren=%b wen=%b expected addr=%h row=%0d reg=%0d ren=%b wen=%b",
                   bus.mem_addr, bus.mem_row, bus.mem_reg, bus.mem_ren, bus.mem_wen,
                   exp_req[0].addr, exp_req[0].row, exp_req[0].mreg, exp_req[0].ren, exp_req[0].wen);
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.ready_out !== 1'b0 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL req_status: busy=%b ready=%b done=%b expected 1 0 0",
                   bus.busy, bus.ready_out, bus.done);
        end
        if (hit && exp_req.size() > 0) void'(exp_req.pop_front());
      end else begin
        checks++;
        if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0 || bus.mem_addr !== '0 ||
            bus.mem_row !== '0 || bus.mem_reg !== '0) begin
          errors++;
          $display("FAIL mem_idle_zero: ren=%b wen=%b addr=%h row=%0d reg=%0d expected all 0",
                   bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_row, bus.mem_reg);
        end
      end
      if (bus.done === 1'b1) begin
        ndone++;
        done_cycle = cyc;
        checks++;
        if (exp_done.size() == 0 || exp_req.size() != 0) begin
          errors++;
          $display("FAIL done_early: done with %0d rows and %0d dones outstanding",
                   exp_req.size(), exp_done.size());
        end else if (bus.done_rd !== exp_done[0].rd || bus.done_ls !== exp_done[0].ls) begin
          errors++;
          $display("FAIL done_fields: rd=%0d ls=%b expected rd=%0d ls=%b",
                   bus.done_rd, bus.done_ls, exp_done[0].rd, exp_done[0].ls);
        end
        if (exp_done.size() > 0) void'(exp_done.pop_front());
      end else if (bus.done_rd !== '0 || bus.done_ls !== 2'b00) begin
        checks++;
        errors++;
        $display("FAIL done_idle_zero: rd=%0d ls=%b expected 0", bus.done_rd, bus.done_ls);
      end
      if (done_cycle > 0 && cyc == done_cycle + 1) begin
        checks++;
        if (bus.ready_out !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL ready_after_done: ready=%b busy=%b expected 1 0", bus.ready_out, bus.busy);
        end
        fin = 1'b1;
      end
      tick();
    end
    bus.mem_hit = 1'b0;
    bus.enable  = 1'b0;
    if (!fin) begin
      errors++;
      $display("FAIL serve_timeout: no completion within 200 cycles");
    end
  endtask

  task automatic test_reset();
    bus.nRST = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.ready_out !== 1'b1 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0 ||
        bus.done !== 1'b0 || bus.mem_addr !== '0 || bus.done_rd !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b req=%b done=%b addr=%h expected 1 0 0 0 0",
               bus.ready_out, bus.busy, bus.mem_req, bus.done, bus.mem_addr);
    end
    bus.nRST = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int dc, nd;
    issue(4'd3, 2'b01, 32'h100, 11'h10, 32'h40);
    serve(1, 0, dc, nd);
    checks++;
    if (dc != ROWS + 1 || nd != 1) begin
      errors++;
      $display("FAIL load_latency: done_cycle=%0d pulses=%0d expected %0d 1", dc, nd, ROWS + 1);
    end
  endtask

  task automatic test_store_wait();
    int dc, nd;
    issue(4'd5, 2'b10, 32'h2000, 11'h0, 32'h20);
    serve(3, 0, dc, nd);
    checks++;
    if (dc != 3 * ROWS + 1 || nd != 1) begin
      errors++;
      $display("FAIL store_latency: done_cycle=%0d pulses=%0d expected %0d 1", dc, nd, 3 * ROWS + 1);
    end
  endtask

  task automatic test_both_bits_and_none();
    int dc, nd;
    issue(4'd1, 2'b11, 32'h0, 11'h4, 32'h0);
    serve(1, 0, dc, nd);
    bus.enable = 1'b1;
    bus.ls_in  = 2'b00;
    bus.rd_in  = 4'd6;
    tick();
    bus.enable = 1'b0;
    tick();
    checks++;
    if (bus.ready_out !== 1'b1 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ls_none_ignored: ready=%b req=%b busy=%b expected 1 0 0",
               bus.ready_out, bus.mem_req, bus.busy);
    end
  endtask

  task automatic test_wrap();
    int dc, nd;
    issue(4'd7, 2'b01, 32'hFFFF_FFF0, 11'h0, 32'h10);
    serve(2, 0, dc, nd);
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL wrap_done: pulses=%0d expected 1", nd);
    end
  endtask

  task automatic test_back_to_back();
    int dc, nd;
    issue(4'd2, 2'b01, 32'h4000, 11'h8, 32'h100);
    serve(1, 2, dc, nd);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.mem_req !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL poke_ignored: req=%b done=%b expected 0 0", bus.mem_req, bus.done);
      end
      tick();
    end
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL single_done: pulses=%0d expected 1", nd);
    end
  endtask

  task automatic test_flush();
    issue(4'd2, 2'b01, 32'h300, 11'h0, 32'h8);
    bus.mem_hit = 1'b1;
    tick();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_row !== 2'd1 || bus.mem_addr !== 32'h308) begin
      errors++;
      $display("FAIL flush_pre_row: req=%b row=%0d addr=%h expected 1 1 00000308",
               bus.mem_req, bus.mem_row, bus.mem_addr);
    end
    bus.flush = 1'b1;
    tick();
    bus.flush   = 1'b0;
    bus.mem_hit = 1'b0;
    checks++;
    if (bus.ready_out !== 1'b1 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: ready=%b req=%b busy=%b done=%b expected 1 0 0 0",
               bus.ready_out, bus.mem_req, bus.busy, bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_done: done=%b expected 0", bus.done);
      end
      tick();
    end
    exp_req.delete();
    exp_done.delete();
    bus.flush  = 1'b1;
    bus.enable = 1'b1;
    bus.ls_in  = 2'b01;
    tick();
    bus.flush  = 1'b0;
    bus.enable = 1'b0;
    bus.ls_in  = 2'b00;
    checks++;
    if (bus.ready_out !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept: ready=%b req=%b expected 1 0", bus.ready_out, bus.mem_req);
    end
  endtask

  task automatic test_async_reset();
    int dc, nd;
    issue(4'd7, 2'b10, 32'h500, 11'h0, 32'h4);
    bus.mem_hit = 1'b1;
    tick();
    tick();
    bus.mem_hit = 1'b0;
    bus.nRST    = 1'b0;
    #1;
    checks++;
    if (bus.ready_out !== 1'b1 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0 ||
        bus.mem_wen !== 1'b0 || bus.mem_addr !== '0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ready=%b busy=%b req=%b wen=%b addr=%h done=%b expected 1 0 0 0 0 0",
               bus.ready_out, bus.busy, bus.mem_req, bus.mem_wen, bus.mem_addr, bus.done);
    end
    tick();
    bus.nRST = 1'b1;
    tick();
    exp_req.delete();
    exp_done.delete();
    issue(4'd4, 2'b01, 32'h600, 11'h2, 32'h10);
    serve(1, 0, dc, nd);
    checks++;
    if (dc != ROWS + 1) begin
      errors++;
      $display("FAIL post_reset_op: done_cycle=%0d expected %0d", dc, ROWS + 1);
    end
  endtask

  initial begin
    bus.nRST      = 1'b0;
    bus.enable    = 1'b0;
    bus.ls_in     = 2'b00;
    bus.rd_in     = '0;
    bus.base_in   = '0;
    bus.imm_in    = '0;
    bus.stride_in = '0;
    bus.flush     = 1'b0;
    bus.mem_hit   = 1'b0;
    test_reset();
    test_load();
    test_store_wait();
    test_both_bits_and_none();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    checks++;
    if (exp_req.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d rows and %0d dones left", exp_req.size(), exp_done.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
